ethernet_mac_tx_arbiter: RTL

- Parametrised N-channel AXI-Stream frame arbiter in front of the MAC transmit path. It merges NUM_CHANNELS byte-wide client streams into the single tx_tdata/tx_tvalid/tx_tready/tx_tuser/tx_tlast stream consumed by the MAC encapsulator.
- Arbitration is round-robin and switches only at frame boundaries.
- Frames longer than MAX_FRAME_BYTES are truncated and marked bad; frames shorter than MIN_FRAME_BYTES are marked bad.
- Output is registered for timing closure at 125 MHz.

---
 rtl/ethernet_mac_tx_arbiter_pkg.sv | 47 ++++
 rtl/ethernet_mac_tx_arbiter_if.sv | 40 ++++
 rtl/ethernet_mac_rr_pick.sv | 35 +++
 rtl/ethernet_mac_tx_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ethernet_mac_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ethernet_mac_pkg
// Shared types, constants and helpers for the MAC transmit frame arbiter.
//   state_t         : arbiter FSM states (IDLE, BUSY, DRAIN)
//   BYTE_W          : width of one client/MAC data beat
//   MAX_CH/MAX_CH_W : upper bound on channel count and its index width
//   rr_pick_onehot  : rotate-priority pick, first requester at or after ptr
// -----------------------------------------------------------------------------
package ethernet_mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int BYTE_W   = 8;
   localparam int MAX_CH   = 16;
   localparam int MAX_CH_W = 4;
   localparam int PICK_W   = MAX_CH_W + 1;

   // Scans channels ptr, ptr+1, ... modulo n and returns a one-hot vector
   // holding the first requester found. n is a constant at every call site,
   // so the loop folds down to a fixed priority rotator.
   function automatic logic [MAX_CH-1:0] rr_pick_onehot(
      input logic [MAX_CH-1:0]   req,
      input logic [MAX_CH_W-1:0] ptr,
      input int                  n
   );
      logic [MAX_CH-1:0] gnt;
      logic [PICK_W-1:0] c;
      logic              found;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         // ptr < n and i < n, so one conditional subtract is a full modulo
         c = {1'b0, ptr} + PICK_W'(i);
         if (c >= PICK_W'(n)) c = c - PICK_W'(n);
         if ((i < n) && !found && req[c[MAX_CH_W-1:0]]) begin
            gnt[c[MAX_CH_W-1:0]] = 1'b1;
            found                = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/ethernet_mac_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// ethernet_mac_tx_arbiter_if
// Bundles the client-side streams and the merged MAC-side stream.
//   s_tdata/s_tvalid/s_tuser/s_tlast : per-channel client stream (channel i
//                                      data in bits [8i+7:8i])
//   s_tready                         : per-channel ready back to clients
//   m_tdata/m_tvalid/m_tuser/m_tlast : merged stream to the MAC encapsulator
//   m_tready                         : MAC ready
// Modports: slave  = the arbiter's view (consumes s_*, produces m_*)
//           master = the surrounding environment's view
// -----------------------------------------------------------------------------
interface ethernet_mac_tx_arbiter_if
   import ethernet_mac_pkg::*;
#(
   parameter int NUM_CHANNELS = 4
);

   logic [NUM_CHANNELS*BYTE_W-1:0] s_tdata;
   logic [NUM_CHANNELS-1:0]        s_tvalid;
   logic [NUM_CHANNELS-1:0]        s_tready;
   logic [NUM_CHANNELS-1:0]        s_tuser;
   logic [NUM_CHANNELS-1:0]        s_tlast;

   logic [BYTE_W-1:0]              m_tdata;
   logic                           m_tvalid;
   logic                           m_tready;
   logic                           m_tuser;
   logic                           m_tlast;

   modport slave (
      input  s_tdata, s_tvalid, s_tuser, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
   );

   modport master (
      output s_tdata, s_tvalid, s_tuser, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
   );

endinterface

// File: rtl/ethernet_mac_rr_pick.sv
// -----------------------------------------------------------------------------
// ethernet_mac_rr_pick
// Combinational round-robin selector.
//   req : per-channel request (s_tvalid)
//   ptr : channel with highest priority this round
//   gnt : one-hot winner (zero when nothing requests)
//   idx : binary index of the winner (zero when nothing requests)
// -----------------------------------------------------------------------------
module ethernet_mac_rr_pick
   import ethernet_mac_pkg::*;
#(
   parameter int NUM_CHANNELS = 4
) (
   input  logic [NUM_CHANNELS-1:0]         req,
   input  logic [$clog2(NUM_CHANNELS)-1:0] ptr,
   output logic [NUM_CHANNELS-1:0]         gnt,
   output logic [$clog2(NUM_CHANNELS)-1:0] idx
);

   localparam int PTR_W = $clog2(NUM_CHANNELS);

   logic [MAX_CH-1:0] gnt_full;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path holds a
      // previous value, which would otherwise infer a latch.
      idx      = '0;
      gnt_full = rr_pick_onehot(MAX_CH'(req), MAX_CH_W'(ptr), NUM_CHANNELS);
      for (int i = 0; i < MAX_CH; i++) begin
         if (gnt_full[i]) idx = PTR_W'(i);
      end
      gnt = gnt_full[NUM_CHANNELS-1:0];
   end

endmodule

// File: rtl/ethernet_mac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// ethernet_mac_tx_arbiter
// Merges NUM_CHANNELS byte-wide client frame streams into one registered
// stream for the MAC transmit path. Ownership changes only at frame
// boundaries, round-robin. Over-long frames are cut at MAX_FRAME_BYTES (last
// beat flagged bad, remainder drained); runts shorter than MIN_FRAME_BYTES
// are flagged bad on their last beat.
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   bus         : client and MAC streams (slave modport)
//   grant       : one-hot owner of the current frame, zero when idle
//   trunc_pulse : one-cycle pulse on the channel whose frame was cut
// -----------------------------------------------------------------------------
module ethernet_mac_tx_arbiter
   import ethernet_mac_pkg::*;
#(
   parameter int NUM_CHANNELS    = 4,
   parameter int MAX_FRAME_BYTES = 1514,
   parameter int MIN_FRAME_BYTES = 14
) (
   input  logic                    clk,
   input  logic                    reset_n,
   ethernet_mac_tx_arbiter_if.slave bus,
   output logic [NUM_CHANNELS-1:0] grant,
   output logic [NUM_CHANNELS-1:0] trunc_pulse
);

   localparam int PTR_W = $clog2(NUM_CHANNELS);
   localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);

   state_t                  state;
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        gidx;
   logic [CNT_W-1:0]        beat_cnt;

   logic [NUM_CHANNELS-1:0] pick_gnt;
   logic [PTR_W-1:0]        pick_idx;

   logic                    out_free;
   logic                    accept;
   logic [BYTE_W-1:0]       sel_data;
   logic                    sel_last;
   logic                    sel_user;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    runt;
   logic                    trunc;
   logic [PTR_W-1:0]        next_ptr;

   ethernet_mac_rr_pick #(
      .NUM_CHANNELS(NUM_CHANNELS)
   ) u_rr_pick (
      .req(bus.s_tvalid),
      .ptr(rr_ptr),
      .gnt(pick_gnt),
      .idx(pick_idx)
   );

   // Owner's beat, selected by the registered index.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      sel_user = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (gidx == PTR_W'(i)) begin
            sel_data = bus.s_tdata[i*BYTE_W +: BYTE_W];
            sel_last = bus.s_tlast[i];
            sel_user = bus.s_tuser[i];
         end
      end
   end

   always_comb begin
      // The output register can take a beat when empty or being emptied.
      out_free = !bus.m_tvalid || bus.m_tready;
      case (state)
         BUSY:    bus.s_tready = out_free ? grant : '0;
         DRAIN:   bus.s_tready = grant;
         default: bus.s_tready = '0;
      endcase
      accept   = |(bus.s_tvalid & bus.s_tready);
      cnt_inc  = beat_cnt + CNT_W'(1);
      runt     = sel_last && (cnt_inc < CNT_W'(MIN_FRAME_BYTES));
      // A last beat landing exactly on the limit is a normal end, not a cut.
      trunc    = !sel_last && (cnt_inc == CNT_W'(MAX_FRAME_BYTES));
      next_ptr = (gidx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : gidx + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         gidx         <= '0;
         beat_cnt     <= '0;
         grant        <= '0;
         trunc_pulse  <= '0;
         bus.m_tdata  <= '0;
         bus.m_tvalid <= 1'b0;
         bus.m_tuser  <= 1'b0;
         bus.m_tlast  <= 1'b0;
      end else begin
         // NOTE: all registered state uses non-blocking assignment so every
         // read in this block sees the pre-edge value.
         trunc_pulse <= '0;
         // Pending beat leaves when the MAC takes it; an accept below
         // overrides this with a fresh beat.
         if (bus.m_tready) bus.m_tvalid <= 1'b0;

         case (state)
            IDLE: begin
               if (|bus.s_tvalid) begin
                  grant <= pick_gnt;
                  gidx  <= pick_idx;
                  state <= BUSY;
               end
            end

            BUSY: begin
               if (accept) begin
                  bus.m_tvalid <= 1'b1;
                  bus.m_tdata  <= sel_data;
                  bus.m_tlast  <= sel_last || trunc;
                  bus.m_tuser  <= sel_user || runt || trunc;
                  if (sel_last) begin
                     rr_ptr   <= next_ptr;
                     beat_cnt <= '0;
                     grant    <= '0;
                     state    <= IDLE;
                  end else if (trunc) begin
                     trunc_pulse <= grant;
                     beat_cnt    <= '0;
                     state       <= DRAIN;
                  end else begin
                     beat_cnt <= cnt_inc;
                  end
               end
            end

            DRAIN: begin
               // Remainder of a cut frame is swallowed until its last beat.
               if (accept && sel_last) begin
                  rr_ptr <= next_ptr;
                  grant  <= '0;
                  state  <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
